// File: rtl/regfile_pkg.sv
// Shared types and constants for the 32x64 architectural register file.
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = 5'd31;

endpackage

// File: rtl/decoder5_32.sv
// 5:32 write-select decoder; one-hot output when enabled, all-zero otherwise.
module decoder5_32 (
  input  logic        en_i,
  input  logic [4:0]  addr_i,
  output logic [31:0] sel_o
);

  always_comb begin
    sel_o = '0;
    if (en_i) begin
      sel_o[addr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/mux32_1.sv
// 32:1 read multiplexer of DATA_W-bit words.
module mux32_1 #(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] data_i [32],
  input  logic [4:0]        sel_i,
  output logic [DATA_W-1:0] data_o
);

  assign data_o = data_i[sel_i];

endmodule

// File: rtl/reg_file_32x64.sv
// Architectural register file: 31 stored regs, X31 reads zero,
// one write port with same-cycle bypass onto two combinational read ports.
module reg_file_32x64 #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic [4:0]        WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [4:0]        ReadRegister1,
  input  logic [4:0]        ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  import regfile_pkg::*;

  logic [31:0]       we;
  logic              unused_we31;
  logic [DATA_W-1:0] regs_q [NUM_REGS-1];
  logic [DATA_W-1:0] regs_d [NUM_REGS-1];
  logic [DATA_W-1:0] rd_vec [NUM_REGS];
  logic [DATA_W-1:0] mux1, mux2;
  logic              byp1, byp2;

  decoder5_32 u_dec (
    .en_i   (RegWrite),
    .addr_i (WriteRegister),
    .sel_o  (we)
  );

  // X31 has no storage, so its decoder line has nothing to load.
  assign unused_we31 = we[ZERO_REG];

  always_comb begin
    for (int k = 0; k < NUM_REGS - 1; k++) begin
      regs_d[k] = we[k] ? WriteData : regs_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS - 1; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_REGS - 1; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REGS - 1; k++) begin
      rd_vec[k] = regs_q[k];
    end
    rd_vec[NUM_REGS-1] = '0;
  end

  mux32_1 #(.DATA_W(DATA_W)) u_mux1 (
    .data_i (rd_vec),
    .sel_i  (ReadRegister1),
    .data_o (mux1)
  );

  mux32_1 #(.DATA_W(DATA_W)) u_mux2 (
    .data_i (rd_vec),
    .sel_i  (ReadRegister2),
    .data_o (mux2)
  );

  assign byp1 = RegWrite && (WriteRegister == ReadRegister1)
             && (ReadRegister1 != ZERO_REG);
  assign byp2 = RegWrite && (WriteRegister == ReadRegister2)
             && (ReadRegister2 != ZERO_REG);

  // Gate with rst_n so a write presented during reset never leaks out.
  assign ReadData1 = !rst_n ? '0 : (byp1 ? WriteData : mux1);
  assign ReadData2 = !rst_n ? '0 : (byp2 ? WriteData : mux2);

endmodule

// File: tb/tb_reg_file_32x64.sv
// Scoreboard bench: stimulus pushes expected reads, monitor pops and compares.
module tb_reg_file_32x64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  reg_file_32x64 dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] r1;
    logic [63:0] r2;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] model [32];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          stim_done = 0;

  function automatic logic [63:0] ref_read(input logic rst, input logic we,
                                           input logic [4:0] wr,
                                           input logic [63:0] wd,
                                           input logic [4:0] rr);
    if (!rst) return 64'd0;
    if (rr == 5'd31) return 64'd0;
    if (we && wr == rr) return wd;
    return model[rr];
  endfunction

  task automatic drive(input logic rst, input logic we, input logic [4:0] wr,
                       input logic [63:0] wd, input logic [4:0] r1,
                       input logic [4:0] r2, input string tag);
    exp_t e;
    @(negedge clk);
    rst_n = rst; RegWrite = we; WriteRegister = wr; WriteData = wd;
    ReadRegister1 = r1; ReadRegister2 = r2;
    if (!rst) begin
      for (int k = 0; k < 32; k++) model[k] = 64'd0;
    end
    e.tag = tag;
    e.r1  = ref_read(rst, we, wr, wd, r1);
    e.r2  = ref_read(rst, we, wr, wd, r2);
    exp_q.push_back(e);
    // the coming rising edge commits the write, except to X31 or under reset
    if (rst && we && wr != 5'd31) model[wr] = wd;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (ReadData1 !== e.r1) begin
          n_fail++;
          $display("FAIL %s rd1: got %h want %h", e.tag, ReadData1, e.r1);
        end
        n_tests++;
        if (ReadData2 !== e.r2) begin
          n_fail++;
          $display("FAIL %s rd2: got %h want %h", e.tag, ReadData2, e.r2);
        end
      end
    end
  end

  initial begin : stim
    logic [4:0]  wr, r1, r2;
    logic [63:0] wd;
    logic        we, rs;
    int          wait_cyc;
    rst_n = 1'b0; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;
    for (int k = 0; k < 32; k++) model[k] = 64'd0;

    for (int i = 0; i < 3; i++)
      drive(0, 1, 5'(i + 1), 64'hABCD, 5'(i + 1), 5'(i + 1), "rst_write");
    for (int i = 0; i < 31; i++)
      drive(1, 0, 0, 0, 5'(i), 5'(30 - i), "post_rst");

    drive(1, 1, 5, 64'hDEAD, 5, 6, "load_x5");
    drive(1, 0, 0, 0, 5, 5, "x5_stored");
    drive(0, 0, 0, 0, 5, 5, "async_rst");
    drive(1, 0, 0, 0, 5, 0, "rst_release");
    for (int i = 0; i < 31; i++)
      drive(1, 0, 0, 0, 5'(i), 5'(i), "rst_clear");

    drive(1, 1, 3, 64'h0123_4567_89AB_CDEF, 4, 0, "wr_x3");
    drive(1, 0, 0, 0, 3, 3, "rd_x3");
    drive(1, 0, 0, 0, 4, 3, "x4_zero");

    drive(1, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 31, "x31_wr");
    drive(1, 0, 0, 0, 31, 31, "x31_after");

    drive(1, 1, 8, 64'h88, 0, 0, "wr_x8");
    drive(1, 1, 7, 64'h42, 7, 8, "bypass");
    drive(1, 0, 0, 0, 7, 8, "bypass_after");

    drive(1, 1, 9, 64'h1234, 0, 0, "wr_x9");
    for (int i = 0; i < 3; i++)
      drive(1, 0, 9, 64'h99, 9, 9, "we_off");

    drive(1, 1, 12, 64'h111, 12, 12, "b2b_a");
    drive(1, 1, 12, 64'h222, 12, 0, "b2b_b");
    drive(1, 0, 0, 0, 12, 12, "b2b_last");

    for (int i = 0; i < 32; i++)
      drive(1, 1, 5'(i), 64'(i) * 64'h1_0000_0001, 5'(i), 5'(31 - i),
            "sweep_wr");
    for (int i = 0; i < 32; i++)
      drive(1, 0, 0, 0, 5'(i), 5'(31 - i), "sweep_rd");

    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 49) != 0);
      we = $urandom_range(0, 3) != 0;
      wr = 5'($urandom);
      wd = {$urandom, $urandom};
      r1 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom);
      r2 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom);
      drive(rs, we, wr, wd, r1, r2, "random");
    end
    drive(1, 0, 0, 0, 0, 0, "tail");

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    #3;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
